// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO and runs mult/div in the
// background behind a fixed-length busy window.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDUop,
  input  logic        E_Start,
  input  logic [31:0] E_Rsout,
  input  logic [31:0] E_Rtout,
  output logic        E_Busy,
  output logic [31:0] E_HIout,
  output logic [31:0] E_LOout,
  output logic [31:0] E_MDUout
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic [CNT_W-1:0] cnt;
  logic [31:0]      t_hi;
  logic [31:0]      t_lo;
  logic             start_c;
  logic [CNT_W-1:0] load_c;
  logic [31:0]      res_hi_c;
  logic [31:0]      res_lo_c;
  logic [63:0]      prod_s_c;
  logic [63:0]      prod_u_c;
  logic [31:0]      rs_mag_c;
  logic [31:0]      rt_mag_c;
  logic [31:0]      uq_c;
  logic [31:0]      ur_c;

  assign start_c = E_Start && !E_Busy &&
                   (E_MDUop == OP_MULT || E_MDUop == OP_MULTU ||
                    E_MDUop == OP_DIV  || E_MDUop == OP_DIVU);

  assign load_c = (E_MDUop == OP_DIV || E_MDUop == OP_DIVU) ? CNT_W'(DIV_CYCLES)
                                                            : CNT_W'(MULT_CYCLES);

  // Full-width result; signed divide works on magnitudes so INT_MIN / -1 wraps cleanly.
  always_comb begin
    res_hi_c = E_HIout;
    res_lo_c = E_LOout;
    prod_s_c = {{32{E_Rsout[31]}}, E_Rsout} * {{32{E_Rtout[31]}}, E_Rtout};
    prod_u_c = {32'd0, E_Rsout} * {32'd0, E_Rtout};
    rs_mag_c = E_Rsout;
    rt_mag_c = E_Rtout;
    uq_c     = 32'd0;
    ur_c     = 32'd0;
    if (E_MDUop == OP_DIV) begin
      rs_mag_c = E_Rsout[31] ? (~E_Rsout + 32'd1) : E_Rsout;
      rt_mag_c = E_Rtout[31] ? (~E_Rtout + 32'd1) : E_Rtout;
    end
    if (E_Rtout != 32'd0) begin
      uq_c = rs_mag_c / rt_mag_c;
      ur_c = rs_mag_c % rt_mag_c;
    end
    case (E_MDUop)
      OP_MULT:  {res_hi_c, res_lo_c} = prod_s_c;
      OP_MULTU: {res_hi_c, res_lo_c} = prod_u_c;
      OP_DIV: begin
        if (E_Rtout != 32'd0) begin
          res_lo_c = (E_Rsout[31] ^ E_Rtout[31]) ? (~uq_c + 32'd1) : uq_c;
          res_hi_c = E_Rsout[31] ? (~ur_c + 32'd1) : ur_c;
        end
      end
      OP_DIVU: begin
        if (E_Rtout != 32'd0) begin
          res_lo_c = uq_c;
          res_hi_c = ur_c;
        end
      end
      default: ;
    endcase
  end

  // Divide by zero latches the current HI/LO so completion leaves them unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      E_HIout <= 32'd0;
      E_LOout <= 32'd0;
      E_Busy  <= 1'b0;
      cnt     <= '0;
      t_hi    <= 32'd0;
      t_lo    <= 32'd0;
    end else if (E_Busy) begin
      if (cnt == CNT_W'(1)) begin
        E_HIout <= t_hi;
        E_LOout <= t_lo;
        E_Busy  <= 1'b0;
        cnt     <= '0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end else if (start_c) begin
      t_hi   <= res_hi_c;
      t_lo   <= res_lo_c;
      cnt    <= load_c;
      E_Busy <= 1'b1;
    end else if (E_MDUop == OP_MTHI) begin
      E_HIout <= E_Rsout;
    end else if (E_MDUop == OP_MTLO) begin
      E_LOout <= E_Rsout;
    end
  end

  always_comb begin
    E_MDUout = 32'd0;
    if (E_MDUop == OP_MFHI) E_MDUout = E_HIout;
    else if (E_MDUop == OP_MFLO) E_MDUout = E_LOout;
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Multiply/divide unit in the Execute stage of the five-stage MIPS pipeline. It consumes the operands and instruction class latched by the Decode-to-Execute pipeline register and owns the HI/LO registers. Multi-cycle operations run in the background and raise a busy flag. The hazard unit uses that flag to stall Decode and hold the Decode-to-Execute register.

## Interface
- MULT_CYCLES, 5, cycles E_Busy stays high for mult/multu
- DIV_CYCLES, 10, cycles E_Busy stays high for div/divu
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- E_MDUop  input  4  op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none
- E_Start  input  1  one-cycle pulse qualifying ops 1-4
- E_Rsout  input  32  rs operand (dividend / multiplicand / mthi-mtlo source)
- E_Rtout  input  32  rt operand (divisor / multiplier)
- E_Busy  output  1  high while a mult/div is in flight
- E_HIout  output  32  current HI register
- E_LOout  output  32  current LO register
- E_MDUout  output  32  combinational: HI when op=5, LO when op=6, else 0

## Operation
- Reset: HI=0, LO=0, E_Busy=0, cycle counter=0, temp result registers=0.
- Start of a multi-cycle op requires E_Start=1, op in 1-4 and E_Busy=0. Then at that edge:
  - Compute the full result into temp registers {tHI,tLO}.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Set E_Busy.
- E_Start while E_Busy=1 is ignored. E_Start with op outside 1-4 is ignored.
- Results:
  - mult: 64-bit signed product; HI=upper, LO=lower.
  - multu: 64-bit unsigned product.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient and remainder.
  - Divide by zero (rt=0): HI/LO unchanged at completion; busy sequence still runs for DIV_CYCLES.
- Each edge while busy, the counter decrements. On the edge where counter==1: HI<=tHI, LO<=tLO, E_Busy<=0, counter<=0.
- mthi/mtlo (op 7/8): write HI/LO from E_Rsout at the edge, only when E_Busy=0; ignored while busy. No E_Start needed.
- mfhi/mflo: read-only, combinational from the HI/LO registers. Reading while busy returns the old value. The hazard unit guarantees this does not occur.
- Stall contract for the hazard unit: stall Decode whenever the Decode instruction is any MDU op (1-8) and (E_Start | E_Busy) is 1. e_mdu itself never flushes or stalls.
- Reset mid-operation: the in-flight result is discarded, HI=LO=0, E_Busy=0 on that edge.
- Reset has priority over every other input.

## Timing
- Start sampled at edge 0. E_Busy=1 after edge 0 through edge N, where N = MULT_CYCLES or DIV_CYCLES, so it is high for exactly N cycles.
- New HI/LO are visible after edge N, the same edge on which E_Busy falls.
- A new E_Start is accepted at edge N+1 at the earliest, giving back-to-back ops with one idle cycle between busy windows.
- mthi/mtlo latency is 1 edge; the value is visible on E_HIout/E_LOout in the next cycle.
- E_MDUout has zero latency, combinational from op and the HI/LO registers.

## Test plan
- Reset, then mult with rs=0xFFFFFFFE (-2), rt=3, start at edge 0:
  - E_Busy high for 5 cycles.
  - After edge 5: HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - E_Busy=0.
- multu with rs=0xFFFFFFFF, rt=2 -> after edge 5, HI=0x00000001, LO=0xFFFFFFFE.
- div with rs=0xFFFFFFF9 (-7), rt=2 -> E_Busy high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu with rt=0 after mthi 0x1234 / mtlo 0x5678:
  - Busy for 10 cycles.
  - HI=0x1234, LO=0x5678 unchanged.
  - mfhi then drives E_MDUout=0x1234.
- Start mult, then at cycle 2 apply E_Start with div and mtlo 0xAAAA:
  - Both are ignored.
  - After edge 5, HI/LO hold only the mult result.
- Start div, assert reset at cycle 4 -> after that edge HI=LO=0, E_Busy=0, and no later update from the cancelled div.
